// File: rtl/mb_audio_decimator.sv
// Box-car decimator + offset removal for Mockingboard PSG sums (optional DC blocker: MB_DC_BLOCK_EN).
// Latency: valid rises two edges after the terminal input; one-deep output reg, overwritten (and counted) on overrun.
module mb_audio_decimator #(
  parameter int DECIM      = 1125,
  parameter int SHIFT      = 10,
  parameter int MIDPOINT   = 384,
  parameter int GAIN_SHIFT = 5,
  parameter int DC_K       = 8
) (
  input  logic        clk_logic,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [9:0]  audio_l_i,
  input  logic [9:0]  audio_r_i,
  output logic [15:0] sample_l_o,
  output logic [15:0] sample_r_o,
  output logic        sample_valid_o,
  input  logic        sample_ready_i,
  output logic [7:0]  overrun_count_o
);

  if (DECIM < 2 || DECIM > 2047) begin : g_bad_decim
    $error("mb_audio_decimator: DECIM must be in 2..2047");
  end
  if (DC_K < 1 || DC_K > 23 || MIDPOINT < 0 || MIDPOINT > 2047) begin : g_bad_dc
    $error("mb_audio_decimator: DC_K or MIDPOINT out of range");
  end

  localparam logic [10:0] LAST = 11'(DECIM - 1);

  function automatic logic signed [15:0] sat16(input logic signed [23:0] v);
    if (v > 24'sd32767)
      return 16'sh7FFF;
    else if (v < -24'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  // Stage 1: accumulate DECIM inputs; terminal input is folded straight into sum.
  logic [10:0] cnt;
  logic [20:0] acc_l, acc_r;
  logic [20:0] sum_l, sum_r;
  logic        stb1;

  always_ff @(posedge clk_logic) begin
    if (reset) begin
      cnt   <= '0;
      acc_l <= '0;
      acc_r <= '0;
      sum_l <= '0;
      sum_r <= '0;
      stb1  <= 1'b0;
    end else if (!enable_i) begin
      cnt   <= '0;
      acc_l <= '0;
      acc_r <= '0;
      stb1  <= 1'b0;
    end else if (cnt == LAST) begin
      sum_l <= acc_l + {11'd0, audio_l_i};
      sum_r <= acc_r + {11'd0, audio_r_i};
      acc_l <= '0;
      acc_r <= '0;
      cnt   <= '0;
      stb1  <= 1'b1;
    end else begin
      acc_l <= acc_l + {11'd0, audio_l_i};
      acc_r <= acc_r + {11'd0, audio_r_i};
      cnt   <= cnt + 11'd1;
      stb1  <= 1'b0;
    end
  end

  // Stage 2: normalise, remove offset, apply gain, saturate.
  logic [10:0]        x_l, x_r;
  logic signed [23:0] y_l, y_r;
  logic signed [15:0] out_l, out_r;
  logic signed [15:0] s2_l, s2_r;
  logic               stb2;

  assign x_l = 11'(sum_l >> SHIFT);
  assign x_r = 11'(sum_r >> SHIFT);

`ifdef MB_DC_BLOCK_EN
  logic [10:0]        xprev_l, xprev_r;
  logic signed [23:0] yprev_l, yprev_r;

  // y carries 8 fractional bits; pole at 1 - 2^-DC_K.
  function automatic logic signed [23:0] dc_next(input logic [10:0] x, input logic [10:0] xp,
                                                 input logic signed [23:0] yp);
    logic signed [23:0] d;
    d = $signed({13'd0, x}) - $signed({13'd0, xp});
    return yp + (d <<< 8) - (yp >>> DC_K);
  endfunction

  always_comb begin
    y_l   = dc_next(x_l, xprev_l, yprev_l);
    y_r   = dc_next(x_r, xprev_r, yprev_r);
    out_l = sat16((y_l >>> 8) <<< GAIN_SHIFT);
    out_r = sat16((y_r >>> 8) <<< GAIN_SHIFT);
  end

  always_ff @(posedge clk_logic) begin
    if (reset) begin
      xprev_l <= '0;
      xprev_r <= '0;
      yprev_l <= '0;
      yprev_r <= '0;
    end else if (stb1) begin
      xprev_l <= x_l;
      xprev_r <= x_r;
      yprev_l <= y_l;
      yprev_r <= y_r;
    end
  end
`else
  localparam logic signed [23:0] MID = 24'(MIDPOINT);

  always_comb begin
    y_l   = ($signed({13'd0, x_l}) - MID) <<< GAIN_SHIFT;
    y_r   = ($signed({13'd0, x_r}) - MID) <<< GAIN_SHIFT;
    out_l = sat16(y_l);
    out_r = sat16(y_r);
  end
`endif

  always_ff @(posedge clk_logic) begin
    if (reset) begin
      s2_l <= '0;
      s2_r <= '0;
      stb2 <= 1'b0;
    end else begin
      stb2 <= stb1;
      if (stb1) begin
        s2_l <= out_l;
        s2_r <= out_r;
      end
    end
  end

  // Stage 3: output register; a new sample always wins over an unaccepted one.
  always_ff @(posedge clk_logic) begin
    if (reset) begin
      sample_l_o      <= '0;
      sample_r_o      <= '0;
      sample_valid_o  <= 1'b0;
      overrun_count_o <= '0;
    end else if (stb2) begin
      sample_l_o     <= s2_l;
      sample_r_o     <= s2_r;
      sample_valid_o <= 1'b1;
      if (sample_valid_o && !sample_ready_i && overrun_count_o != 8'hFF)
        overrun_count_o <= overrun_count_o + 8'd1;
    end else if (sample_valid_o && sample_ready_i) begin
      sample_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mb_audio_decimator.sv
// Scoreboard bench for mb_audio_decimator with DECIM=4, SHIFT=2.
module tb_mb_audio_decimator;

  logic        clk_logic = 1'b0;
  logic        reset;
  logic        enable_i;
  logic [9:0]  audio_l_i;
  logic [9:0]  audio_r_i;
  logic [15:0] sample_l_o;
  logic [15:0] sample_r_o;
  logic        sample_valid_o;
  logic        sample_ready_i;
  logic [7:0]  overrun_count_o;

  always #5 clk_logic = ~clk_logic;

  mb_audio_decimator #(.DECIM(4), .SHIFT(2)) dut (
    .clk_logic      (clk_logic),
    .reset          (reset),
    .enable_i       (enable_i),
    .audio_l_i      (audio_l_i),
    .audio_r_i      (audio_r_i),
    .sample_l_o     (sample_l_o),
    .sample_r_o     (sample_r_o),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .overrun_count_o(overrun_count_o)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_period = 1'b0;
  int   prev_cyc = -1;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk_logic) cyc <= cyc + 1;

  // Monitor: every accepted sample must match the head of the scoreboard.
  always @(negedge clk_logic) begin
    exp_t e;
    if (!reset && sample_valid_o && sample_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got L=%0d R=%0d, expected none",
                 $signed(sample_l_o), $signed(sample_r_o));
      end else begin
        e = sb.pop_front();
        check("sample_l", $signed(sample_l_o), $signed(e.l));
        check("sample_r", $signed(sample_r_o), $signed(e.r));
      end
      if (chk_period) begin
        if (prev_cyc >= 0) check("valid_period", cyc - prev_cyc, 4);
        prev_cyc = cyc;
      end else begin
        prev_cyc = -1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_logic);
      #1;
    end
  endtask

  task automatic push(input int l, input int r);
    exp_t e;
    e.l = 16'(l);
    e.r = 16'(r);
    sb.push_back(e);
  endtask

  task automatic frame(input int l, input int r);
    enable_i  = 1'b1;
    audio_l_i = 10'(l);
    audio_r_i = 10'(r);
    step(4);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, sample_valid_o, 0);
    check({tag, "_l"}, sample_l_o, 0);
    check({tag, "_r"}, sample_r_o, 0);
    check({tag, "_ovr"}, overrun_count_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d samples still expected", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    enable_i       = 1'b0;
    audio_l_i      = '0;
    audio_r_i      = '0;
    sample_ready_i = 1'b0;
    step(3);
    check_zero("reset");
    reset = 1'b0;
    step(1);

`ifdef MB_DC_BLOCK_EN
    // Step 0 -> 765 from reset, then decay by 255/256 per sample.
    sample_ready_i = 1'b1;
    push(24480, 24480);
    push(24384, 24384);
    push(24288, 24288);
    push(24192, 24192);
    repeat (4) frame(765, 765);
    enable_i = 1'b0;
    step(3);
`else
    // Midpoint input gives silence; check latency N+2 on the first frame.
    sample_ready_i = 1'b1;
    push(0, 0);
    frame(384, 384);
    enable_i = 1'b0;
    check("lat_edge_n", sample_valid_o, 0);
    step(1);
    check("lat_edge_n1", sample_valid_o, 0);
    step(1);
    check("lat_edge_n2", sample_valid_o, 1);
    step(2);
    repeat (3) begin
      push(0, 0);
      frame(384, 384);
    end
    enable_i = 1'b0;
    step(3);

    // Full-scale left, zero right, ready tied high: one sample every 4 clocks.
    chk_period = 1'b1;
    repeat (3) begin
      push(12192, -12288);
      frame(765, 0);
    end
    enable_i = 1'b0;
    step(3);
    chk_period = 1'b0;

    // Ready low across three samples: only the newest survives, two overruns.
    sample_ready_i = 1'b0;
    frame(765, 0);
    frame(384, 384);
    push(-12288, 12192);
    frame(0, 765);
    enable_i = 1'b0;
    step(2);
    check("ovr_valid", sample_valid_o, 1);
    check("ovr_count2", overrun_count_o, 2);
    sample_ready_i = 1'b1;
    step(1);
    check("ovr_accept_valid", sample_valid_o, 0);
    check("ovr_accept_count", overrun_count_o, 2);
    sample_ready_i = 1'b0;

    // 300 unaccepted samples saturate the counter.
    push(0, 0);
    repeat (300) frame(384, 384);
    enable_i = 1'b0;
    step(2);
    check("ovr_sat", overrun_count_o, 255);
    check("ovr_sat_valid", sample_valid_o, 1);
    sample_ready_i = 1'b1;
    step(1);
    sample_ready_i = 1'b0;

    // Reset with a pending sample and a partial accumulation (cnt=2).
    frame(500, 500);
    audio_l_i = 10'd700;
    audio_r_i = 10'd700;
    step(2);
    check("pre_reset_valid", sample_valid_o, 1);
    reset = 1'b1;
    step(1);
    check_zero("midreset");
    reset          = 1'b0;
    sample_ready_i = 1'b1;
    push(-4288, 12160);
    enable_i  = 1'b1;
    audio_l_i = 10'd100; audio_r_i = 10'd764; step(1);
    audio_l_i = 10'd200; audio_r_i = 10'd765; step(1);
    audio_l_i = 10'd300; audio_r_i = 10'd765; step(1);
    audio_l_i = 10'd400; audio_r_i = 10'd765; step(1);
    enable_i = 1'b0;
    step(3);

    // Enable dropped mid-frame: pending sample held, partial frame discarded.
    sample_ready_i = 1'b0;
    push(6912, 6912);
    frame(600, 600);
    audio_l_i = 10'd765;
    audio_r_i = 10'd765;
    step(2);
    enable_i = 1'b0;
    step(10);
    check("gap_valid_held", sample_valid_o, 1);
    check("gap_no_overrun", overrun_count_o, 0);
    sample_ready_i = 1'b1;
    step(1);
    check("gap_accept", sample_valid_o, 0);
    push(-12288, -12288);
    frame(0, 0);
    enable_i = 1'b0;
    check("reen_edge_n", sample_valid_o, 0);
    step(1);
    check("reen_edge_n1", sample_valid_o, 0);
    step(1);
    check("reen_edge_n2", sample_valid_o, 1);
    step(2);
`endif

    step(4);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
